adder59_share_scheduler: RTL and testbench
==========================================

Name: adder59_share_scheduler

Overview:
- Shares one 59+30-bit unsigned adder datapath (60-bit sum) between NUM_REQ requesters in the multiplier partial-product accumulation path.
- Round-robin arbitration, valid/ready handshake per requester, registered operands and registered result.
- A single response channel returns the sum tagged with the granted requester index.
- Sits between the partial-product generators and the final-product accumulation stage.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- IDX_W, 1, width of the requester index; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NUM_REQ*59  packed operand A; requester i occupies bits [i*59 +: 59].
- req_b  input  NUM_REQ*30  packed operand B; requester i occupies bits [i*30 +: 30].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_sum  output  60  A + zero-extended B.
- rsp_idx  output  IDX_W  index of the requester that produced rsp_sum.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, operand regs=0, rsp_sum=0, rsp_idx=0, rsp_valid=0, req_ready=0, busy=0.
- FSM states and transitions:
  - IDLE: req_ready[g] is high combinationally when req_valid is nonzero; g is the round-robin winner.
    - On the handshake, latch req_a[g], req_b[g] and g, then go to EXEC.
    - rr_ptr becomes (g+1) mod NUM_REQ.
  - EXEC: one cycle. The adder operates on the registered operands, with B zero-extended to 59 bits. The sum is registered into rsp_sum. Go to RESP.
  - RESP: rsp_valid=1. rsp_sum and rsp_idx are held stable until rsp_valid && rsp_ready, then go to IDLE.
- Round-robin rule: search starts at rr_ptr and ascends with wrap. Priority rotates only on a grant, never on idle cycles.
- Latency: handshake in cycle N, rsp_valid in cycle N+2.
  - Throughput without the optional feature is one request per 3 cycles when rsp_ready is held high.
- Arithmetic: rsp_sum = {1'b0,A} + {30'b0,B} as a full 60-bit result, with no truncation. Bit 59 is the carry out.
- req_ready is 0 in EXEC and RESP. A requester that drops req_valid before being granted gets nothing; this is legal.
- A requester must hold req_a and req_b stable while valid and not ready. The block samples only on the handshake.
- Ports with req_valid=0 are skipped by the search. NUM_REQ must not be a non-power-of-two above 4.
- rsp_ready low in RESP: stall indefinitely, outputs stable, no new grants.
- Reset mid-operation: any state returns to IDLE immediately, and the in-flight result is dropped.

Optional Feature:
- Macro ADDSCHED_BYPASS_EN.
- Defined:
  - In RESP with rsp_ready=1, arbitration runs in the same cycle. A winner gets req_ready, and the FSM goes straight to EXEC instead of IDLE.
  - The winning requester's operands are latched in that cycle and rr_ptr advances.
  - Throughput becomes one result per 2 cycles; latency is unchanged.
- Undefined: RESP always returns to IDLE, and req_ready stays 0 in RESP.

Decomposition:
- Package adder59_sched_pkg holds:
  - Width constants A_W=59, B_W=30, SUM_W=60.
  - State enum {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (NUM_REQ, IDX_W):
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and its index.
  - Purely combinational.
- The adder is the existing 59-bit unsigned ripple-carry adder, instantiated once inside this block.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 one cycle after a grant -> rsp_valid=0, busy=0, state IDLE, rr_ptr=0, no response emitted after release.
- Single request: req 0 with A=59'h1, B=30'h3 -> req_ready[0] in cycle N; rsp_valid in cycle N+2 with rsp_sum=60'h4, rsp_idx=0.
- Carry out: A=2^59-1, B=2^30-1 -> rsp_sum=60'h8000_0003FFF_FFFE with bit 59=1.
- Round robin: both requesters held valid, 4 transactions -> grant order 0,1,0,1, each rsp_idx matches its own operands.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_sum and rsp_idx stable, req_ready=0 throughout; the result is accepted on the first cycle rsp_ready=1.
- ADDSCHED_BYPASS_EN: continuous requests with rsp_ready=1 -> rsp_valid on alternate cycles (period 2). Without the macro the period is 3.

Source files
------------

// File: rtl/adder59_sched_pkg.sv
// Shared widths, FSM encoding and the operand adder for adder59_share_scheduler.
package adder59_sched_pkg;

   localparam int A_W   = 59;
   localparam int B_W   = 30;
   localparam int SUM_W = 60;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_e;

   // Full-width unsigned add: A widened by one carry bit, B zero-extended.
   function automatic logic [SUM_W-1:0] add_ab(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
      return {1'b0, a} + {{(SUM_W-B_W){1'b0}}, b};
   endfunction

endpackage

// File: rtl/adder59_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at rr_ptr and ascends with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [31:0]      cand_s;
   logic [IDX_W-1:0] cand_idx_s;
   logic             found_s;

   // First requesting port at or after rr_ptr wins.
   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      found_s    = 1'b0;
      cand_s     = 32'd0;
      cand_idx_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s     = (32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ);
         cand_idx_s = IDX_W'(cand_s);
         if (enable && !found_s && req[cand_idx_s]) begin
            grant[cand_idx_s] = 1'b1;
            grant_idx         = cand_idx_s;
            found_s           = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/adder59_share_scheduler.sv
// One shared 59+30-bit adder time-multiplexed between NUM_REQ requesters, round-robin.
// Optional macro ADDSCHED_BYPASS_EN lets RESP re-arbitrate and go straight to EXEC.
module adder59_share_scheduler
   import adder59_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [SUM_W-1:0]       rsp_sum,
   output logic [IDX_W-1:0]       rsp_idx,
   output logic                   busy
);

`ifdef ADDSCHED_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   sched_state_e       state_r;
   sched_state_e       state_nxt_s;
   logic [IDX_W-1:0]   rr_ptr_r;
   logic [IDX_W-1:0]   rr_ptr_nxt_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               arb_en_s;
   logic               hs_s;
   logic [A_W-1:0]     a_r;
   logic [B_W-1:0]     b_r;
   logic [IDX_W-1:0]   idx_r;
   logic [SUM_W-1:0]   sum_r;
   logic [IDX_W-1:0]   rsp_idx_r;
   logic               rsp_valid_r;
   logic               busy_r;

   // Arbitration window: IDLE, or an accepted RESP when bypass is built in; never during reset.
   always_comb begin
      arb_en_s = 1'b0;
      if (!rst_n) begin
         arb_en_s = 1'b0;
      end else if (state_r == IDLE) begin
         arb_en_s = 1'b1;
      end else if (BYPASS && (state_r == RESP) && rsp_ready) begin
         arb_en_s = 1'b1;
      end else begin
         arb_en_s = 1'b0;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_r),
      .enable    (arb_en_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   assign req_ready    = grant_s;
   assign hs_s         = |grant_s;
   assign rr_ptr_nxt_s = IDX_W'((32'(grant_idx_s) + 32'd1) % 32'(NUM_REQ));

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (hs_s) state_nxt_s = EXEC;
            else      state_nxt_s = IDLE;
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (rsp_ready && hs_s)  state_nxt_s = EXEC;
            else if (rsp_ready)     state_nxt_s = IDLE;
            else                    state_nxt_s = RESP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, priority pointer and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rr_ptr_r    <= '0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         rsp_valid_r <= (state_nxt_s == RESP);
         busy_r      <= (state_nxt_s != IDLE);
         if (hs_s) rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   // Operand capture on handshake; result capture in EXEC so the response holds through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         idx_r     <= '0;
         sum_r     <= '0;
         rsp_idx_r <= '0;
      end else begin
         if (hs_s) begin
            a_r   <= req_a[grant_idx_s*A_W +: A_W];
            b_r   <= req_b[grant_idx_s*B_W +: B_W];
            idx_r <= grant_idx_s;
         end
         if (state_r == EXEC) begin
            sum_r     <= add_ab(a_r, b_r);
            rsp_idx_r <= idx_r;
         end
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign busy      = busy_r;
   assign rsp_sum   = sum_r;
   assign rsp_idx   = rsp_idx_r;

endmodule

// File: tb/tb_adder59_share_scheduler.sv
// Directed bench with scoreboard and round-robin model for adder59_share_scheduler.
module tb_adder59_share_scheduler;
   import adder59_sched_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int IDX_W   = 1;
`ifdef ADDSCHED_BYPASS_EN
   localparam int PERIOD  = 2;
   localparam logic [1:0] BP_READY = 2'b10;
`else
   localparam int PERIOD  = 3;
   localparam logic [1:0] BP_READY = 2'b00;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [SUM_W-1:0]       rsp_sum;
   logic [IDX_W-1:0]       rsp_idx;
   logic                   busy;

   adder59_share_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_idx(rsp_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SUM_W-1:0] sum;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t             sb_q[$];
   int               grant_log[$];
   int               rsp_times[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               n_grant  = 0;
   int               n_rsp    = 0;
   logic [IDX_W-1:0] rr_m;
   logic             stall_prev = 1'b0;
   logic [SUM_W-1:0] sum_prev;
   logic [IDX_W-1:0] idx_prev;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check60(input string tag, input logic [59:0] obs, input logic [59:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: model arbitration, push expectations on handshake, pop on response.
   int   win, g, c;
   logic found;
   exp_t e;
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         rr_m       = '0;
         stall_prev = 1'b0;
      end else begin
         check60("ready_onehot", 60'($onehot0(req_ready)), 60'd1);
         if (|(req_valid & req_ready)) begin
            win = 0; found = 1'b0; g = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
               c = (int'(rr_m) + k) % NUM_REQ;
               if (!found && req_valid[c]) begin win = c; found = 1'b1; end
               if (req_ready[k]) g = k;
            end
            check60("rr_winner", 60'(g), 60'(win));
            e.sum = {1'b0, req_a[win*A_W +: A_W]} + {30'b0, req_b[win*B_W +: B_W]};
            e.idx = IDX_W'(win);
            sb_q.push_back(e);
            grant_log.push_back(g);
            n_grant++;
            rr_m = IDX_W'((win + 1) % NUM_REQ);
         end
         if (stall_prev) begin
            check60("stall_valid", 60'(rsp_valid), 60'd1);
            check60("stall_sum", rsp_sum, sum_prev);
            check60("stall_idx", 60'(rsp_idx), 60'(idx_prev));
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            assert (sb_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_rsp observed=%h expected=none", rsp_sum);
            end
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check60("rsp_sum", rsp_sum, e.sum);
               check60("rsp_idx", 60'(rsp_idx), 60'(e.idx));
            end
            rsp_times.push_back(cyc);
            n_rsp++;
         end
         stall_prev = rsp_valid && !rsp_ready;
         sum_prev   = rsp_sum;
         idx_prev   = rsp_idx;
      end
   end

   task automatic drive_pt();
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp_valid(input int max_cyc, input string tag);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) break;
      end
      check60(tag, 60'(rsp_valid), 60'd1);
   endtask

   task automatic wait_drain(input int max_cyc, input string tag);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk); #1;
         if (busy === 1'b0 && sb_q.size() == 0) break;
      end
      check60(tag, 60'(busy), 60'd0);
   endtask

   int base, tbase;

   initial begin
      rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      @(negedge clk);
      check60("rst_valid", 60'(rsp_valid), 60'd0);
      check60("rst_busy", 60'(busy), 60'd0);
      check60("rst_ready", 60'(req_ready), 60'd0);
      check60("rst_sum", rsp_sum, 60'd0);
      check60("rst_idx", 60'(rsp_idx), 60'd0);
      drive_pt();
      rst_n = 1'b1; req_valid = 2'b00;

      // Single request, latency N -> N+2
      drive_pt();
      req_a[0 +: A_W] = 59'h1; req_b[0 +: B_W] = 30'h3; req_valid = 2'b01;
      @(negedge clk);
      check60("single_ready", 60'(req_ready), 60'd1);
      drive_pt(); req_valid = 2'b00;
      @(negedge clk);
      check60("single_n1_valid", 60'(rsp_valid), 60'd0);
      check60("single_n1_busy", 60'(busy), 60'd1);
      @(negedge clk);
      check60("single_n2_valid", 60'(rsp_valid), 60'd1);
      check60("single_sum", rsp_sum, 60'h4);
      check60("single_idx", 60'(rsp_idx), 60'd0);
      @(negedge clk);
      check60("single_done_busy", 60'(busy), 60'd0);

      // Carry out through requester 1
      drive_pt();
      req_a[A_W +: A_W] = {59{1'b1}}; req_b[B_W +: B_W] = {30{1'b1}}; req_valid = 2'b10;
      @(negedge clk);
      check60("carry_ready", 60'(req_ready), 60'd2);
      drive_pt(); req_valid = 2'b00;
      wait_rsp_valid(5, "carry_valid");
      check60("carry_sum", rsp_sum, 60'h800_0000_3FFF_FFFE);
      check60("carry_bit59", 60'(rsp_sum[59]), 60'd1);
      check60("carry_idx", 60'(rsp_idx), 60'd1);
      wait_drain(10, "carry_drain");

      // Round robin, both held valid for four grants
      drive_pt();
      req_a[0 +: A_W] = 59'h123_4567_89AB; req_b[0 +: B_W] = 30'h1000;
      req_a[A_W +: A_W] = 59'h700_0000_0000_0001; req_b[B_W +: B_W] = 30'h2A_BCDE;
      req_valid = 2'b11;
      base = n_grant;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (n_grant >= base + 4) break;
      end
      check60("rr_grant_count", 60'(n_grant - base), 60'd4);
      drive_pt(); req_valid = 2'b00;
      wait_drain(20, "rr_drain");
      for (int i = 0; i < 4; i++)
         check60($sformatf("rr_order%0d", i), 60'(grant_log[base + i]), 60'(i % 2));

      // Backpressure: five stalled cycles in RESP while requester 1 waits
      drive_pt();
      rsp_ready = 1'b0;
      req_a[0 +: A_W] = 59'h55; req_b[0 +: B_W] = 30'hAA; req_valid = 2'b01;
      @(negedge clk);
      check60("bp_ready", 60'(req_ready), 60'd1);
      drive_pt(); req_valid = 2'b10;
      wait_rsp_valid(5, "bp_valid");
      for (int i = 0; i < 5; i++) begin
         check60("bp_no_grant", 60'(req_ready), 60'd0);
         @(negedge clk);
      end
      check60("bp_still_valid", 60'(rsp_valid), 60'd1);
      drive_pt(); rsp_ready = 1'b1;
      @(negedge clk);
      check60("bp_accept_valid", 60'(rsp_valid), 60'd1);
      check60("bp_accept_ready", 60'(req_ready), 60'(BP_READY));
      drive_pt(); req_valid = 2'b00;
      @(negedge clk);
      check60("bp_released", 60'(rsp_valid), 60'd0);
      wait_drain(10, "bp_drain");

      // Throughput with continuous requests
      drive_pt();
      req_valid = 2'b11;
      base = n_rsp; tbase = rsp_times.size();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (n_rsp >= base + 5) break;
      end
      check60("tp_count", 60'(n_rsp - base), 60'd5);
      drive_pt(); req_valid = 2'b00;
      for (int i = 1; i < 5; i++)
         check60("tp_period", 60'(rsp_times[tbase + i] - rsp_times[tbase + i - 1]), 60'(PERIOD));
      wait_drain(20, "tp_drain");

      // Reset one cycle after a grant
      drive_pt();
      req_valid = 2'b01;
      @(negedge clk);
      check60("rst_mid_ready", 60'(req_ready), 60'd1);
      drive_pt();
      rst_n = 1'b0; req_valid = 2'b00;
      #1;
      check60("rst_mid_valid", 60'(rsp_valid), 60'd0);
      check60("rst_mid_busy", 60'(busy), 60'd0);
      drive_pt(); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check60("rst_mid_no_rsp", 60'(rsp_valid), 60'd0);
      end
      drive_pt(); req_valid = 2'b11;
      @(negedge clk);
      check60("rst_mid_rr0", 60'(req_ready), 60'd1);
      drive_pt(); req_valid = 2'b00;
      wait_drain(10, "rst_mid_drain");
      check60("sb_empty", 60'(sb_q.size()), 60'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
